fault_sm_param: RTL and testbench
=================================

Name: fault_sm_param

Overview:
Parametrised successor of the XGMII receive link-fault state machine. Runs at COLS XGMII columns per clock (1, 2 or 4), so it serves 32-, 64- and 128-bit receive datapaths. It qualifies local/remote fault ordered sets against a configurable message threshold and column window. It also provides status, one-cycle interrupt pulses, sticky flags and saturating fault-entry counters for the CPU register block.

Parameters:
COLS, 2, XGMII columns per beat; legal values 1, 2, 4
FAULT_THRESH, 4, same-type fault messages required inside the window to declare a fault; range 2..15
WINDOW_COLS, 128, column window length; range 16..1024
CNT_W, 16, width of the fault-entry counters

Ports:
clk_xgmii_rx  in  1  receive clock
reset_xgmii_rx  in  1  synchronous, active-high reset
cfg_fault_en  in  1  0: force INIT and clear counters/status; sticky flags and event counters are held
local_fault_msg_det  in  COLS  bit i: column i holds a local fault sequence
remote_fault_msg_det  in  COLS  bit i: column i holds a remote fault sequence
status_local_fault_crx  out  1  link in FAULT state with type LOCAL
status_remote_fault_crx  out  1  link in FAULT state with type REMOTE
link_fault  out  2  current qualified fault type: 0 OK, 1 LOCAL, 2 REMOTE
int_local_fault  out  1  one-cycle pulse on rising edge of status_local_fault_crx
int_remote_fault  out  1  one-cycle pulse on rising edge of status_remote_fault_crx
sticky_local_fault  out  1  latched copy of int_local_fault
sticky_remote_fault  out  1  latched copy of int_remote_fault
sticky_clr  in  1  pulse: clears both sticky flags
cnt_clr  in  1  pulse: clears both counters
local_fault_cnt  out  CNT_W  saturating count of FAULT entries with type LOCAL
remote_fault_cnt  out  CNT_W  saturating count of FAULT entries with type REMOTE

Behaviour:
- Reset: all outputs are 0; state INIT; col_cnt, seq_cnt and last_type are 0/OK.
- Per-beat combinational decode:
  - any_f = |(local | remote).
  - seq_type = LOCAL if any local bit is set, else REMOTE if any remote bit is set, else OK.
  - seq_add = popcount of the local vector if seq_type is LOCAL, else popcount of the remote vector.
  - f_idx = lowest set index of (local | remote).
- Counter widths:
  - col_cnt is wide enough to hold WINDOW_COLS+2*COLS.
  - seq_cnt saturates at FAULT_THRESH.
- INIT:
  - on any_f: last_type <= seq_type; col_cnt <= COLS-f_idx; seq_cnt <= seq_add.
  - go to FAULT (link_fault <= seq_type) if seq_add >= FAULT_THRESH, else go to COUNT.
  - no fault: stay in INIT.
- COUNT (checks evaluated in order, using the registered col_cnt):
  - col_cnt >= WINDOW_COLS -> INIT.
  - !any_f and col_cnt+COLS > WINDOW_COLS -> INIT.
  - any_f and seq_type != last_type -> restart: last_type, col_cnt and seq_cnt are loaded as in INIT; stay in COUNT (no extra bubble state).
  - any_f, same type, seq_cnt+seq_add >= FAULT_THRESH -> FAULT; link_fault <= seq_type; col_cnt <= 0.
  - otherwise col_cnt += COLS and seq_cnt += seq_add.
- FAULT:
  - any_f, same type -> col_cnt <= 0.
  - any_f, new type -> restart into COUNT as above; link_fault is held until the new type qualifies.
  - !any_f and col_cnt+COLS > WINDOW_COLS -> INIT; link_fault <= OK.
  - otherwise col_cnt += COLS.
- Status outputs:
  - registered from state and link_fault; one cycle latency after the FAULT entry edge.
  - a LOCAL->REMOTE change inside FAULT drops the old status when link_fault updates.
- Interrupts, sticky flags and counters:
  - int_* asserts in the same cycle its status rises.
  - sticky_* sets in the same cycle as its int_*; if set and sticky_clr coincide, set wins.
  - each *_fault_cnt increments in the same cycle as its int_*; it saturates at all-ones.
  - if an increment and cnt_clr coincide, the counter loads 1.
- cfg_fault_en=0: state INIT, status and link_fault forced to 0 next cycle; no int pulse is generated.
- Reset mid-FAULT: everything returns to reset values next edge; no int pulse.

Decomposition:
- Shared package fault_pkg holds:
  - LINK_FAULT_OK/LOCAL/REMOTE encodings;
  - the state enum INIT/COUNT/FAULT;
  - a popcount function.
- One sub-module, fault_stat, handles one fault type: edge detect, int pulse, sticky flag and saturating counter. It is instantiated twice.

Test Plan (COLS=2, THRESH=4, WINDOW=128):
1. local=2'b11 for 2 beats -> FAULT at edge after beat 2. status_local rises 1 cycle later with a 1-cycle int_local_fault; local_fault_cnt=1; link_fault=1.
2. local=2'b01 once every 21 beats -> FAULT on the 4th message. With a 22-beat period -> return to INIT on beat 64; status never asserts.
3. local=2'b11 for 1 beat, then remote=2'b11 for 2 beats -> link_fault=2 and status_remote=1; status_local never asserts.
4. In FAULT, remove all faults -> INIT at the 65th fault-free beat; status deasserts 1 cycle later; no int pulse.
5. CNT_W=2, five fault entries -> counter reads 3. sticky_clr coincident with int_local_fault -> sticky stays 1. sticky_clr alone -> sticky goes to 0.
6. reset_xgmii_rx or cfg_fault_en=0 while in FAULT -> status=0 and link_fault=0 next cycle. After release, a full 2-beat qualification is needed again.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared encodings, FSM state type and helpers for the parametrised XGMII
// receive link-fault state machine.
package fault_pkg;

   localparam logic [1:0] LINK_FAULT_OK     = 2'd0;
   localparam logic [1:0] LINK_FAULT_LOCAL  = 2'd1;
   localparam logic [1:0] LINK_FAULT_REMOTE = 2'd2;

   localparam int unsigned MAX_COLS = 4;
   localparam int unsigned ADD_W    = 3;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   // Number of set bits in a per-beat column vector (up to four columns).
   function automatic logic [ADD_W-1:0] popcount(input logic [MAX_COLS-1:0] v);
      logic [ADD_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(MAX_COLS); i++) begin
         n = n + ADD_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/fault_stat.sv
// Per-fault-type status bookkeeping: status register, rising-edge interrupt
// pulse, sticky flag and saturating entry counter.
module fault_stat #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flt_i,
   input  logic             sticky_clr_i,
   input  logic             cnt_clr_i,
   output logic             status_o,
   output logic             int_o,
   output logic             sticky_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic             status_q;
   logic             int_q;
   logic             sticky_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             rise_c;

   assign rise_c = flt_i & ~status_q;

   // A coincident clear and increment leaves the counter at one.
   always_comb begin
      cnt_d = cnt_q;
      if (rise_c) begin
         if (cnt_clr_i) begin
            cnt_d = CNT_W'(1);
         end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (cnt_clr_i) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         status_q <= 1'b0;
         int_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         status_q <= flt_i;
         int_q    <= rise_c;
         sticky_q <= rise_c | (sticky_q & ~sticky_clr_i);
         cnt_q    <= cnt_d;
      end
   end

   assign status_o = status_q;
   assign int_o    = int_q;
   assign sticky_o = sticky_q;
   assign cnt_o    = cnt_q;

endmodule

// File: rtl/fault_sm_param.sv
// XGMII receive link-fault qualification at COLS columns per beat, with
// per-type status, interrupt, sticky and counter outputs.
module fault_sm_param
   import fault_pkg::*;
#(
   parameter int unsigned COLS         = 2,
   parameter int unsigned FAULT_THRESH = 4,
   parameter int unsigned WINDOW_COLS  = 128,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk_xgmii_rx,
   input  logic             reset_xgmii_rx,
   input  logic             cfg_fault_en,
   input  logic [COLS-1:0]  local_fault_msg_det,
   input  logic [COLS-1:0]  remote_fault_msg_det,
   output logic             status_local_fault_crx,
   output logic             status_remote_fault_crx,
   output logic [1:0]       link_fault,
   output logic             int_local_fault,
   output logic             int_remote_fault,
   output logic             sticky_local_fault,
   output logic             sticky_remote_fault,
   input  logic             sticky_clr,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] local_fault_cnt,
   output logic [CNT_W-1:0] remote_fault_cnt
);

   localparam int unsigned COL_W = $clog2(WINDOW_COLS + 2 * COLS + 1);
   localparam int unsigned SEQ_W = $clog2(FAULT_THRESH + 1);
   localparam int unsigned SUM_W = SEQ_W + 1;

   state_e           state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [1:0]       last_q, last_d;
   logic [1:0]       lf_q, lf_d;

   logic [COLS-1:0]  any_vec;
   logic             any_f;
   logic [1:0]       seq_type;
   logic [ADD_W-1:0] seq_add;
   logic [ADD_W-1:0] f_idx;
   logic [COL_W-1:0] ld_col;
   logic [COL_W-1:0] col_inc;
   logic [SUM_W-1:0] seq_sum;
   logic             add_qual;
   logic             sum_qual;
   logic             flt_local_c;
   logic             flt_remote_c;

   function automatic logic [SEQ_W-1:0] sat_seq(input logic [SUM_W-1:0] v);
      return (v >= SUM_W'(FAULT_THRESH)) ? SEQ_W'(FAULT_THRESH) : SEQ_W'(v);
   endfunction

   // Per-beat decode; local faults take priority when both types appear.
   always_comb begin
      any_vec  = local_fault_msg_det | remote_fault_msg_det;
      any_f    = |any_vec;
      seq_type = LINK_FAULT_OK;
      if (|local_fault_msg_det) begin
         seq_type = LINK_FAULT_LOCAL;
      end else if (|remote_fault_msg_det) begin
         seq_type = LINK_FAULT_REMOTE;
      end
      seq_add = (|local_fault_msg_det) ? popcount(MAX_COLS'(local_fault_msg_det))
                                       : popcount(MAX_COLS'(remote_fault_msg_det));
      f_idx = '0;
      for (int i = int'(COLS) - 1; i >= 0; i--) begin
         if (any_vec[i]) begin
            f_idx = ADD_W'(i);
         end
      end
   end

   assign ld_col   = COL_W'(COLS) - COL_W'(f_idx);
   assign col_inc  = col_q + COL_W'(COLS);
   assign seq_sum  = SUM_W'(seq_q) + SUM_W'(seq_add);
   assign add_qual = SUM_W'(seq_add) >= SUM_W'(FAULT_THRESH);
   assign sum_qual = seq_sum >= SUM_W'(FAULT_THRESH);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      seq_d   = seq_q;
      last_d  = last_q;
      lf_d    = lf_q;
      unique case (state_q)
         ST_INIT: begin
            if (any_f) begin
               last_d = seq_type;
               col_d  = ld_col;
               seq_d  = sat_seq(SUM_W'(seq_add));
               if (add_qual) begin
                  state_d = ST_FAULT;
                  lf_d    = seq_type;
               end else begin
                  state_d = ST_COUNT;
               end
            end
         end
         ST_COUNT: begin
            if (col_q >= COL_W'(WINDOW_COLS) ||
                (!any_f && col_inc > COL_W'(WINDOW_COLS))) begin
               state_d = ST_INIT;
               col_d   = '0;
               seq_d   = '0;
               lf_d    = LINK_FAULT_OK;
            end else if (any_f && seq_type != last_q) begin
               last_d = seq_type;
               col_d  = ld_col;
               seq_d  = sat_seq(SUM_W'(seq_add));
            end else if (any_f && sum_qual) begin
               state_d = ST_FAULT;
               lf_d    = seq_type;
               col_d   = '0;
               seq_d   = sat_seq(seq_sum);
            end else begin
               col_d = col_inc;
               seq_d = sat_seq(seq_sum);
            end
         end
         ST_FAULT: begin
            if (any_f && seq_type == last_q) begin
               col_d = '0;
            end else if (any_f) begin
               // New fault type: requalify while still reporting the old one.
               state_d = ST_COUNT;
               last_d  = seq_type;
               col_d   = ld_col;
               seq_d   = sat_seq(SUM_W'(seq_add));
            end else if (col_inc > COL_W'(WINDOW_COLS)) begin
               state_d = ST_INIT;
               col_d   = '0;
               seq_d   = '0;
               lf_d    = LINK_FAULT_OK;
            end else begin
               col_d = col_inc;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
      if (!cfg_fault_en) begin
         state_d = ST_INIT;
         col_d   = '0;
         seq_d   = '0;
         last_d  = LINK_FAULT_OK;
         lf_d    = LINK_FAULT_OK;
      end
   end

   always_ff @(posedge clk_xgmii_rx) begin
      if (reset_xgmii_rx) begin
         state_q <= ST_INIT;
         col_q   <= '0;
         seq_q   <= '0;
         last_q  <= LINK_FAULT_OK;
         lf_q    <= LINK_FAULT_OK;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         seq_q   <= seq_d;
         last_q  <= last_d;
         lf_q    <= lf_d;
      end
   end

   assign link_fault   = lf_q;
   assign flt_local_c  = cfg_fault_en && (lf_q == LINK_FAULT_LOCAL);
   assign flt_remote_c = cfg_fault_en && (lf_q == LINK_FAULT_REMOTE);

   fault_stat #(.CNT_W(CNT_W)) u_stat_local (
      .clk_i        (clk_xgmii_rx),
      .rst_i        (reset_xgmii_rx),
      .flt_i        (flt_local_c),
      .sticky_clr_i (sticky_clr),
      .cnt_clr_i    (cnt_clr),
      .status_o     (status_local_fault_crx),
      .int_o        (int_local_fault),
      .sticky_o     (sticky_local_fault),
      .cnt_o        (local_fault_cnt)
   );

   fault_stat #(.CNT_W(CNT_W)) u_stat_remote (
      .clk_i        (clk_xgmii_rx),
      .rst_i        (reset_xgmii_rx),
      .flt_i        (flt_remote_c),
      .sticky_clr_i (sticky_clr),
      .cnt_clr_i    (cnt_clr),
      .status_o     (status_remote_fault_crx),
      .int_o        (int_remote_fault),
      .sticky_o     (sticky_remote_fault),
      .cnt_o        (remote_fault_cnt)
   );

endmodule

// File: tb/tb_fault_sm_param.sv
// Scoreboard bench for fault_sm_param at COLS=2, THRESH=4, WINDOW=128, CNT_W=2.
module tb_fault_sm_param;

   localparam int unsigned COLS  = 2;
   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [1:0]       lf;
      logic             stl;
      logic             str;
      logic             il;
      logic             ir;
      logic             skl;
      logic             skr;
      logic [CNT_W-1:0] cl;
      logic [CNT_W-1:0] cr;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [COLS-1:0]  loc_det;
   logic [COLS-1:0]  rem_det;
   logic             st_clr;
   logic             c_clr;
   logic             stat_l, stat_r;
   logic [1:0]       lf;
   logic             int_l, int_r;
   logic             sk_l, sk_r;
   logic [CNT_W-1:0] cnt_l, cnt_r;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // Reference state: previous expected outputs
   logic [1:0]       m_lf  = 2'd0;
   logic             m_stl = 1'b0, m_str = 1'b0;
   logic             m_skl = 1'b0, m_skr = 1'b0;
   logic [CNT_W-1:0] m_cl  = '0,   m_cr  = '0;

   always #5 clk = ~clk;

   fault_sm_param #(
      .COLS(COLS), .FAULT_THRESH(4), .WINDOW_COLS(128), .CNT_W(CNT_W)
   ) dut (
      .clk_xgmii_rx            (clk),
      .reset_xgmii_rx          (rst),
      .cfg_fault_en            (en),
      .local_fault_msg_det     (loc_det),
      .remote_fault_msg_det    (rem_det),
      .status_local_fault_crx  (stat_l),
      .status_remote_fault_crx (stat_r),
      .link_fault              (lf),
      .int_local_fault         (int_l),
      .int_remote_fault        (int_r),
      .sticky_local_fault      (sk_l),
      .sticky_remote_fault     (sk_r),
      .sticky_clr              (st_clr),
      .cnt_clr                 (c_clr),
      .local_fault_cnt         (cnt_l),
      .remote_fault_cnt        (cnt_r)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic rise, input logic clr);
      if (rise) return clr ? CNT_W'(1) : ((&c) ? c : c + CNT_W'(1));
      return clr ? '0 : c;
   endfunction

   // One beat: drive columns, push expectation, pop and compare after the edge.
   task automatic beat(input logic [1:0] l, input logic [1:0] r, input logic [1:0] exp_lf);
      exp_t e, o;
      loc_det = l;
      rem_det = r;
      e = '0;
      if (!rst) begin
         e.lf  = exp_lf;
         e.stl = en && (m_lf == 2'd1);
         e.str = en && (m_lf == 2'd2);
         e.il  = e.stl && !m_stl;
         e.ir  = e.str && !m_str;
         e.skl = e.il | (m_skl & ~st_clr);
         e.skr = e.ir | (m_skr & ~st_clr);
         e.cl  = cnt_next(m_cl, e.il, c_clr);
         e.cr  = cnt_next(m_cr, e.ir, c_clr);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      check("link_fault", 32'(lf), 32'(o.lf));
      check("status",     32'({stat_l, stat_r}), 32'({o.stl, o.str}));
      check("int",        32'({int_l, int_r}),   32'({o.il, o.ir}));
      check("sticky",     32'({sk_l, sk_r}),     32'({o.skl, o.skr}));
      check("cnt_local",  32'(cnt_l), 32'(o.cl));
      check("cnt_remote", 32'(cnt_r), 32'(o.cr));
      m_lf  = o.lf;
      m_stl = o.stl;
      m_str = o.str;
      m_skl = o.skl;
      m_skr = o.skr;
      m_cl  = o.cl;
      m_cr  = o.cr;
   endtask

   // Fault-free beats out of FAULT: exit on the 65th, status drops one later.
   task automatic drain(input logic [1:0] held);
      for (int k = 1; k <= 66; k++) begin
         beat(2'b00, 2'b00, (k >= 65) ? 2'd0 : held);
      end
   endtask

   task automatic qualify_local();
      beat(2'b11, 2'b00, 2'd0);
      beat(2'b11, 2'b00, 2'd1);
      beat(2'b00, 2'b00, 2'd1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; st_clr = 1'b0; c_clr = 1'b0;
      loc_det = '0; rem_det = '0;
      #1;
      beat(2'b00, 2'b00, 2'd0);
      beat(2'b11, 2'b00, 2'd0);
      rst = 1'b0;

      // Back-to-back full local columns, then window expiry
      beat(2'b11, 2'b00, 2'd0);
      beat(2'b11, 2'b00, 2'd1);
      drain(2'd1);

      // Local then remote: requalifies as remote only
      beat(2'b11, 2'b00, 2'd0);
      beat(2'b00, 2'b11, 2'd0);
      beat(2'b00, 2'b11, 2'd2);
      drain(2'd2);

      // Sparse local messages, 21-beat spacing qualifies on the fourth
      for (int i = 0; i < 64; i++) begin
         beat((i % 21 == 0) ? 2'b01 : 2'b00, 2'b00, (i == 63) ? 2'd1 : 2'd0);
      end
      drain(2'd1);

      // 22-beat spacing expires the window before the fourth message
      for (int i = 0; i < 67; i++) begin
         beat((i % 22 == 0) ? 2'b01 : 2'b00, 2'b00, 2'd0);
      end
      for (int i = 0; i < 70; i++) beat(2'b00, 2'b00, 2'd0);

      // Sticky clear alone, then coincident with a new interrupt
      st_clr = 1'b1;
      beat(2'b00, 2'b00, 2'd0);
      st_clr = 1'b0;
      beat(2'b11, 2'b00, 2'd0);
      beat(2'b11, 2'b00, 2'd1);
      st_clr = 1'b1;
      beat(2'b00, 2'b00, 2'd1);
      st_clr = 1'b0;

      // Disable drops FAULT; two more entries saturate the counter
      en = 1'b0;
      beat(2'b00, 2'b00, 2'd0);
      beat(2'b11, 2'b00, 2'd0);
      en = 1'b1;
      qualify_local();
      en = 1'b0;
      beat(2'b00, 2'b00, 2'd0);
      en = 1'b1;
      qualify_local();

      // Synchronous reset mid-FAULT, then full requalification
      rst = 1'b1;
      beat(2'b11, 2'b00, 2'd0);
      rst = 1'b0;
      beat(2'b11, 2'b00, 2'd0);
      beat(2'b11, 2'b00, 2'd1);
      c_clr = 1'b1;
      beat(2'b00, 2'b00, 2'd1);
      beat(2'b00, 2'b00, 2'd1);
      c_clr = 1'b0;

      // Local to remote change while in FAULT
      beat(2'b00, 2'b11, 2'd1);
      beat(2'b00, 2'b11, 2'd2);
      beat(2'b00, 2'b00, 2'd2);
      beat(2'b00, 2'b00, 2'd2);
      en = 1'b0;
      beat(2'b00, 2'b00, 2'd0);
      en = 1'b1;
      beat(2'b00, 2'b00, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
